// File: rtl/instr_pkg.sv
// Shared MIPS instruction-word layout: field bit positions, opcodes with
// special immediate handling, and the split-field bundle type.
package instr_pkg;

    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 26;
    localparam int RS_HI     = 25;
    localparam int RS_LO     = 21;
    localparam int RT_HI     = 20;
    localparam int RT_LO     = 16;
    localparam int RD_HI     = 15;
    localparam int RD_LO     = 11;
    localparam int SHAMT_HI  = 10;
    localparam int SHAMT_LO  = 6;
    localparam int FUNCT_HI  = 5;
    localparam int FUNCT_LO  = 0;
    localparam int IMM_HI    = 15;
    localparam int IMM_LO    = 0;
    localparam int JINDEX_HI = 25;
    localparam int JINDEX_LO = 0;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [15:0] immediate;
        logic [25:0] jindex;
    } instr_fields_t;

endpackage

// File: rtl/instr_field_split.sv
// Combinational splitter: one 32-bit instruction word into R/I/J fields plus
// an EXT_WIDTH immediate (zero-extended for logical ops, sign-extended otherwise).
module instr_field_split
    import instr_pkg::*;
#(
    parameter int EXT_WIDTH = 32
) (
    input  logic [31:0]          i_instr,
    output instr_fields_t        o_fields,
    output logic [EXT_WIDTH-1:0] o_imm_ext
);

    function automatic logic [EXT_WIDTH-1:0] extend_imm(input logic [5:0]  op,
                                                        input logic [15:0] imm);
        if (op == OP_ANDI || op == OP_ORI || op == OP_XORI)
            return EXT_WIDTH'(imm);
        return EXT_WIDTH'($signed(imm));
    endfunction

    assign o_fields.opcode    = i_instr[OPCODE_HI:OPCODE_LO];
    assign o_fields.rs        = i_instr[RS_HI:RS_LO];
    assign o_fields.rt        = i_instr[RT_HI:RT_LO];
    assign o_fields.rd        = i_instr[RD_HI:RD_LO];
    assign o_fields.shamt     = i_instr[SHAMT_HI:SHAMT_LO];
    assign o_fields.funct     = i_instr[FUNCT_HI:FUNCT_LO];
    assign o_fields.immediate = i_instr[IMM_HI:IMM_LO];
    assign o_fields.jindex    = i_instr[JINDEX_HI:JINDEX_LO];
    assign o_imm_ext          = extend_imm(i_instr[OPCODE_HI:OPCODE_LO],
                                           i_instr[IMM_HI:IMM_LO]);

endmodule

// File: rtl/instr_split_queue.sv
// DEPTH-entry fetch-to-decode instruction queue presenting split fields of the head word.
// Optional same-cycle bypass into an empty queue: define INSTR_SPLIT_BYPASS_EN.
module instr_split_queue
    import instr_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int EXT_WIDTH = 32,
    parameter int PC_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_instr,
    input  logic [PC_WIDTH-1:0]    in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [5:0]             opcode,
    output logic [4:0]             rs,
    output logic [4:0]             rt,
    output logic [4:0]             rd,
    output logic [4:0]             shamt,
    output logic [5:0]             funct,
    output logic [15:0]            immediate,
    output logic [EXT_WIDTH-1:0]   imm_ext,
    output logic [25:0]            jindex,
    output logic [PC_WIDTH-1:0]    out_pc,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [31:0]          r_instr [DEPTH];
    logic [PC_WIDTH-1:0]  r_pc    [DEPTH];
    logic [PW-1:0]        r_rd_ptr;
    logic [PW-1:0]        r_wr_ptr;
    logic [CW-1:0]        r_count;

    logic                 w_empty;
    logic                 w_push;
    logic                 w_store;
    logic                 w_deq;
    logic [31:0]          w_head_instr;
    logic [PC_WIDTH-1:0]  w_head_pc;
    instr_fields_t        w_head_fields;
    logic [EXT_WIDTH-1:0] w_head_imm_ext;
    instr_fields_t        w_fields;
    logic [EXT_WIDTH-1:0] w_imm_ext;
    logic [PC_WIDTH-1:0]  w_pc;

    assign w_empty  = (r_count == '0);
    assign in_ready = (r_count != FULL_CNT);
    assign w_push   = in_valid & in_ready;
    assign count    = r_count;

    // Empty queue reads as an all-zero word so every field output is 0.
    assign w_head_instr = w_empty ? '0 : r_instr[r_rd_ptr];
    assign w_head_pc    = w_empty ? '0 : r_pc[r_rd_ptr];

    instr_field_split #(.EXT_WIDTH(EXT_WIDTH)) u_split_head (
        .i_instr   (w_head_instr),
        .o_fields  (w_head_fields),
        .o_imm_ext (w_head_imm_ext)
    );

`ifdef INSTR_SPLIT_BYPASS_EN
    logic [31:0]          w_byp_instr;
    instr_fields_t        w_byp_fields;
    logic [EXT_WIDTH-1:0] w_byp_imm_ext;

    // A word consumed straight through an empty queue is never stored.
    assign out_valid   = w_empty ? (in_valid & ~flush) : 1'b1;
    assign w_store     = w_push & ~flush & ~(w_empty & out_ready);
    assign w_deq       = out_valid & out_ready & ~w_empty;
    assign w_byp_instr = out_valid ? in_instr : '0;

    instr_field_split #(.EXT_WIDTH(EXT_WIDTH)) u_split_byp (
        .i_instr   (w_byp_instr),
        .o_fields  (w_byp_fields),
        .o_imm_ext (w_byp_imm_ext)
    );

    assign w_fields  = w_empty ? w_byp_fields  : w_head_fields;
    assign w_imm_ext = w_empty ? w_byp_imm_ext : w_head_imm_ext;
    assign w_pc      = w_empty ? (out_valid ? in_pc : '0) : w_head_pc;
`else
    assign out_valid = ~w_empty;
    assign w_store   = w_push & ~flush;
    assign w_deq     = out_valid & out_ready;
    assign w_fields  = w_head_fields;
    assign w_imm_ext = w_head_imm_ext;
    assign w_pc      = w_head_pc;
`endif

    assign opcode    = w_fields.opcode;
    assign rs        = w_fields.rs;
    assign rt        = w_fields.rt;
    assign rd        = w_fields.rd;
    assign shamt     = w_fields.shamt;
    assign funct     = w_fields.funct;
    assign immediate = w_fields.immediate;
    assign jindex    = w_fields.jindex;
    assign imm_ext   = w_imm_ext;
    assign out_pc    = w_pc;

    // Queue control: rst beats flush beats push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_store) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_deq)   r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_store && !w_deq)      r_count <= r_count + CW'(1);
            else if (!w_store && w_deq) r_count <= r_count - CW'(1);
        end
    end

    // Entry storage: no reset, validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_instr[r_wr_ptr] <= in_instr;
            r_pc[r_wr_ptr]    <= in_pc;
        end
    end

endmodule

// File: tb/tb_instr_split_queue.sv
// Directed self-checking bench for instr_split_queue (DEPTH=4, EXT_WIDTH=32).
// Bypass scenario runs when INSTR_SPLIT_BYPASS_EN is defined.
module tb_instr_split_queue;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic        in_ready, out_valid;
    logic [31:0] in_instr, in_pc;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] immediate;
    logic [31:0] imm_ext, out_pc;
    logic [25:0] jindex;
    logic [2:0]  count;

    int n_tests = 0;
    int n_fail  = 0;

    instr_split_queue #(.DEPTH(4), .EXT_WIDTH(32), .PC_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .immediate(immediate), .imm_ext(imm_ext), .jindex(jindex),
        .out_pc(out_pc), .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input int k);
        return {6'(k), 26'(k * 37 + 5)};
    endfunction

    task automatic test_reset();
        rst = 1; flush = 0; in_valid = 0; out_ready = 0; in_instr = 0; in_pc = 0;
        tick(); tick();
        rst = 0;
        tick();
        n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_tests++; if ({opcode, jindex, funct} !== 38'd0) begin n_fail++; $display("FAIL reset_fields got %h want 0", {opcode, jindex, funct}); end
        n_tests++; if (imm_ext !== 32'd0) begin n_fail++; $display("FAIL reset_imm_ext got %h want 0", imm_ext); end
        n_tests++; if (out_pc !== 32'd0) begin n_fail++; $display("FAIL reset_out_pc got %h want 0", out_pc); end
        // reset mid-transfer with a push in the reset cycle
        in_valid = 1; in_instr = 32'h1234_5678; in_pc = 32'h40;
        tick(); tick();
        n_tests++; if (count !== 3'd2) begin n_fail++; $display("FAIL prereset_count got %0d want 2", count); end
        rst = 1;
        tick();
        rst = 0; in_valid = 0;
        n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL midreset_count got %0d want 0", count); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_fields();
        out_ready = 0; in_valid = 1; in_instr = 32'hFC00_0000; in_pc = 32'h100;
        tick();
        n_tests++; if (count !== 3'd1) begin n_fail++; $display("FAIL fields_count1 got %0d want 1", count); end
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL fields_valid got %b want 1", out_valid); end
        n_tests++; if (opcode !== 6'h3F) begin n_fail++; $display("FAIL fields_opcode got %h want 3f", opcode); end
        n_tests++; if (out_pc !== 32'h100) begin n_fail++; $display("FAIL fields_pc0 got %h want 100", out_pc); end
        in_instr = 32'h0000_07C0; in_pc = 32'h104;
        tick();
        in_instr = 32'h0000_FFFF; in_pc = 32'h108;
        tick();
        in_valid = 0;
        n_tests++; if (count !== 3'd3) begin n_fail++; $display("FAIL fields_count3 got %0d want 3", count); end
        n_tests++; if (opcode !== 6'h3F) begin n_fail++; $display("FAIL fields_hold got %h want 3f", opcode); end
        out_ready = 1;
        tick();
        n_tests++; if (shamt !== 5'h1F) begin n_fail++; $display("FAIL fields_shamt got %h want 1f", shamt); end
        n_tests++; if (opcode !== 6'h00) begin n_fail++; $display("FAIL fields_op2 got %h want 0", opcode); end
        n_tests++; if (out_pc !== 32'h104) begin n_fail++; $display("FAIL fields_pc1 got %h want 104", out_pc); end
        tick();
        n_tests++; if (immediate !== 16'hFFFF) begin n_fail++; $display("FAIL fields_imm got %h want ffff", immediate); end
        n_tests++; if (imm_ext !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL fields_imm_ext got %h want ffffffff", imm_ext); end
        n_tests++; if ({rd, funct} !== 11'h7FF) begin n_fail++; $display("FAIL fields_rd_funct got %h want 7ff", {rd, funct}); end
        tick();
        out_ready = 0;
        n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL fields_drain got %0d want 0", count); end
        n_tests++; if (immediate !== 16'h0) begin n_fail++; $display("FAIL fields_empty_imm got %h want 0", immediate); end
    endtask

    task automatic test_imm_ext();
        logic [31:0] w   [5] = '{32'h3000_FFFF, 32'h2000_FFFF, 32'h3400_8000, 32'h3C00_8000, 32'h3800_7FFF};
        logic [31:0] exp [5] = '{32'h0000_FFFF, 32'hFFFF_FFFF, 32'h0000_8000, 32'hFFFF_8000, 32'h0000_7FFF};
        for (int i = 0; i < 5; i++) begin
            out_ready = 0; in_valid = 1; in_instr = w[i]; in_pc = 32'h200 + 32'(i * 4);
            tick();
            in_valid = 0;
            n_tests++; if (imm_ext !== exp[i]) begin n_fail++; $display("FAIL imm_ext_%0d got %h want %h", i, imm_ext, exp[i]); end
            out_ready = 1;
            tick();
            out_ready = 0;
        end
        n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL imm_ext_drain got %0d want 0", count); end
    endtask

    task automatic test_full_wrap();
        logic [31:0] q[$];
        logic [31:0] pq[$];
        int cnt_m = 0;
        int k = 1;
        logic acc, pop;
        out_ready = 0; in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            in_instr = mk(k); in_pc = 32'(k * 4);
            #1;
            acc = (cnt_m != 4);
            n_tests++; if (in_ready !== acc) begin n_fail++; $display("FAIL fill_in_ready_%0d got %b want %b", i, in_ready, acc); end
            tick();
            if (acc) begin q.push_back(mk(k)); pq.push_back(32'(k * 4)); cnt_m++; k++; end
        end
        n_tests++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_count got %0d want 4", count); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got %b want 0", in_ready); end
        out_ready = 1;
        for (int i = 0; i < 14; i++) begin
            in_instr = mk(k); in_pc = 32'(k * 4);
            #1;
            acc = (cnt_m != 4);
            pop = (cnt_m != 0);
            n_tests++; if (in_ready !== acc || out_valid !== pop) begin n_fail++; $display("FAIL stream_hs_%0d got %b%b want %b%b", i, in_ready, out_valid, acc, pop); end
            if (pop) begin
                n_tests++; if ({opcode, jindex} !== q[0] || out_pc !== pq[0]) begin n_fail++; $display("FAIL stream_head_%0d got %h/%h want %h/%h", i, {opcode, jindex}, out_pc, q[0], pq[0]); end
            end
            tick();
            if (pop) begin void'(q.pop_front()); void'(pq.pop_front()); cnt_m--; end
            if (acc) begin q.push_back(mk(k)); pq.push_back(32'(k * 4)); cnt_m++; k++; end
            if (i == 0) begin
                n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL unfull_in_ready got %b want 1", in_ready); end
                n_tests++; if (count !== 3'd3) begin n_fail++; $display("FAIL unfull_count got %0d want 3", count); end
            end
        end
        in_valid = 0;
        for (int i = 0; i < 8 && cnt_m > 0; i++) begin
            #1;
            n_tests++; if ({opcode, jindex} !== q[0]) begin n_fail++; $display("FAIL drain_head_%0d got %h want %h", i, {opcode, jindex}, q[0]); end
            tick();
            void'(q.pop_front()); void'(pq.pop_front()); cnt_m--;
        end
        out_ready = 0;
        n_tests++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_empty got %0d/%b want 0/0", count, out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 0; in_valid = 1;
        for (int i = 1; i <= 3; i++) begin
            in_instr = 32'h0800_0000 + 32'(i); in_pc = 32'h300 + 32'(i);
            tick();
        end
        n_tests++; if (count !== 3'd3) begin n_fail++; $display("FAIL preflush_count got %0d want 3", count); end
        flush = 1; in_instr = 32'hDEAD_BEEF; in_pc = 32'h3FC;
        tick();
        flush = 0; in_valid = 0;
        n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL flush_count got %0d want 0", count); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b want 0", out_valid); end
        tick();
        n_tests++; if (count !== 3'd0 || opcode !== 6'h0) begin n_fail++; $display("FAIL flush_ghost got %0d/%h want 0/0", count, opcode); end
        in_valid = 1; in_instr = 32'h0C00_00AA; in_pc = 32'h400;
        tick();
        in_valid = 0;
        n_tests++; if (count !== 3'd1) begin n_fail++; $display("FAIL postflush_count got %0d want 1", count); end
        n_tests++; if ({opcode, jindex} !== 32'h0C00_00AA) begin n_fail++; $display("FAIL postflush_head got %h want 0c0000aa", {opcode, jindex}); end
        out_ready = 1;
        tick();
        out_ready = 0;
        n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL postflush_pop got %0d want 0", count); end
    endtask

`ifdef INSTR_SPLIT_BYPASS_EN
    task automatic test_bypass();
        in_valid = 1; out_ready = 1; in_instr = 32'h3000_1234; in_pc = 32'h500;
        #1;
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL byp_valid got %b want 1", out_valid); end
        n_tests++; if (opcode !== 6'h0C || imm_ext !== 32'h0000_1234) begin n_fail++; $display("FAIL byp_fields got %h/%h want 0c/00001234", opcode, imm_ext); end
        n_tests++; if (out_pc !== 32'h500) begin n_fail++; $display("FAIL byp_pc got %h want 500", out_pc); end
        tick();
        n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL byp_count0 got %0d want 0", count); end
        out_ready = 0; in_instr = 32'h2000_8001; in_pc = 32'h504;
        #1;
        n_tests++; if (out_valid !== 1'b1 || imm_ext !== 32'hFFFF_8001) begin n_fail++; $display("FAIL byp_stall got %b/%h want 1/ffff8001", out_valid, imm_ext); end
        tick();
        in_valid = 0;
        n_tests++; if (count !== 3'd1 || opcode !== 6'h08) begin n_fail++; $display("FAIL byp_store got %0d/%h want 1/08", count, opcode); end
        out_ready = 1;
        tick();
        out_ready = 0; flush = 1; in_valid = 1; in_instr = 32'h1111_1111;
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL byp_flush_valid got %b want 0", out_valid); end
        tick();
        flush = 0; in_valid = 0;
        n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL byp_flush_count got %0d want 0", count); end
    endtask
`endif

    initial begin
        test_reset();
        test_fields();
        test_imm_ext();
        test_full_wrap();
        test_flush();
`ifdef INSTR_SPLIT_BYPASS_EN
        test_bypass();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
